// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel stream router: pixel layout, compositing
// modes and the raster-order coordinate compare used by the stream aligner.
package pixel_pkg;

    localparam int X_W_DEF   = 11;
    localparam int Y_W_DEF   = 11;
    localparam int COL_W_DEF = 16;
    localparam int KEY_MAX   = 32;

    typedef struct packed {
        logic [X_W_DEF-1:0]   x;
        logic [Y_W_DEF-1:0]   y;
        logic [COL_W_DEF-1:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_KEY   = 2'd1,
        MODE_SPLIT = 2'd2
    } mode_e;

    // Keys are {y, x}, so a plain magnitude compare gives raster order.
    function automatic logic coord_lt(input logic [KEY_MAX-1:0] a, input logic [KEY_MAX-1:0] b);
        return a < b;
    endfunction

    // The reserved encoding behaves as pass-through.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_KEY;
            2'd2:    return MODE_SPLIT;
            default: return MODE_PASS;
        endcase
    endfunction

endpackage

// File: rtl/pixel_join.sv
// Two-stream coordinate aligner: decides pops, emits and realignment drops,
// and tracks whether background and foreground are currently in step.
module pixel_join
    import pixel_pkg::*;
#(
    parameter int KEY_W = X_W_DEF + Y_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             join_en,
    input  logic             bg_valid,
    input  logic             fg_valid,
    input  logic             out_full,
    input  logic [KEY_W-1:0] bg_key,
    input  logic [KEY_W-1:0] fg_key,
    input  logic             force_unlock,
    output logic             pop_bg,
    output logic             pop_fg,
    output logic             emit,
    output logic             drop,
    output logic             locked
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_e;

    lock_e state_q, state_d;
    logic  heads_ok;
    logic  keys_eq;
    logic  bg_zero;
    logic  fg_zero;
    logic  bg_lags;

    always_comb begin
        heads_ok = bg_valid & fg_valid & ~out_full;
        keys_eq  = (bg_key == fg_key);
        bg_zero  = (bg_key == '0);
        fg_zero  = (fg_key == '0);
        // A frame-start head is never the laggard; the other stream gives way.
        bg_lags  = ~bg_zero & (fg_zero | coord_lt(KEY_MAX'(bg_key), KEY_MAX'(fg_key)));

        pop_bg = 1'b0;
        pop_fg = 1'b0;
        emit   = 1'b0;
        drop   = 1'b0;
        if (!join_en) begin
            pop_bg = bg_valid & ~out_full;
            emit   = pop_bg;
        end else if (heads_ok) begin
            if (keys_eq) begin
                pop_bg = 1'b1;
                pop_fg = 1'b1;
                emit   = 1'b1;
            end else begin
                drop   = 1'b1;
                pop_bg = bg_lags;
                pop_fg = ~bg_lags;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (force_unlock || drop) begin
            state_d = ST_UNLOCKED;
        end else if (emit) begin
            state_d = ST_LOCKED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule

// File: rtl/pixel_stream_router.sv
// Selects and composites up to two frame-aligned pixel streams into the DAC FIFO,
// reloading its configuration only when a background frame starts.
module pixel_stream_router
    import pixel_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int COL_W  = COL_W_DEF,
    parameter int PIX_W  = X_W + Y_W + COL_W,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              cfg_mode,
    input  logic [CH_W-1:0]         cfg_bg_sel,
    input  logic [CH_W-1:0]         cfg_fg_sel,
    input  logic [COL_W-1:0]        cfg_key_colour,
    input  logic [X_W-1:0]          cfg_split_x,
    input  logic [NUM_CH*PIX_W-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_empty,
    output logic [NUM_CH-1:0]       in_rd_en,
    output logic [PIX_W-1:0]        out_data,
    output logic                    out_wr_en,
    input  logic                    out_full,
    output logic                    sync_locked,
    output logic [15:0]             stat_drop_count,
    output logic [15:0]             stat_frame_count
);

    localparam int SEL_N = 1 << CH_W;
    localparam int KEY_W = X_W + Y_W;

    logic [X_W-1:0]   head_x [SEL_N];
    logic [Y_W-1:0]   head_y [SEL_N];
    logic [COL_W-1:0] head_c [SEL_N];
    logic [SEL_N-1:0] head_empty;
    logic [SEL_N-1:0] head_zero;

    mode_e            mode_q, mode_eff;
    logic [CH_W-1:0]  bg_q, fg_q, bg_eff, fg_eff;
    logic [COL_W-1:0] key_q, key_eff;
    logic [X_W-1:0]   split_q, split_eff;
    logic             lookahead;
    logic             join_en;
    logic             reload;
    logic             force_unlock;
    logic             pop_bg, pop_fg, emit, drop, locked;
    logic [COL_W-1:0] colour_d;
    logic [PIX_W-1:0] out_data_q;
    logic             out_wr_en_q;
    logic [15:0]      drop_cnt_q, frame_cnt_q;

    // Selector codes beyond NUM_CH see a permanently empty channel.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_N; gi++) begin : g_head
            if (gi < NUM_CH) begin : g_real
                assign head_x[gi]     = in_data[gi*PIX_W + Y_W + COL_W +: X_W];
                assign head_y[gi]     = in_data[gi*PIX_W + COL_W +: Y_W];
                assign head_c[gi]     = in_data[gi*PIX_W +: COL_W];
                assign head_empty[gi] = in_empty[gi];
            end else begin : g_tie
                assign head_x[gi]     = '0;
                assign head_y[gi]     = '0;
                assign head_c[gi]     = '0;
                assign head_empty[gi] = 1'b1;
            end
            assign head_zero[gi] = (head_x[gi] == '0) && (head_y[gi] == '0);
        end
    endgenerate

    // When the requested background is at a frame start, the incoming config
    // already governs this cycle so the first pixel of the frame is built with it.
    always_comb begin
        lookahead = ~head_empty[cfg_bg_sel] & head_zero[cfg_bg_sel];
        if (lookahead) begin
            mode_eff  = decode_mode(cfg_mode);
            bg_eff    = cfg_bg_sel;
            fg_eff    = cfg_fg_sel;
            key_eff   = cfg_key_colour;
            split_eff = cfg_split_x;
        end else begin
            mode_eff  = mode_q;
            bg_eff    = bg_q;
            fg_eff    = fg_q;
            key_eff   = key_q;
            split_eff = split_q;
        end
        join_en = (mode_eff != MODE_PASS) && (fg_eff != bg_eff);
    end

    pixel_join #(
        .KEY_W (KEY_W)
    ) u_join (
        .clk          (clk),
        .rst          (rst),
        .join_en      (join_en),
        .bg_valid     (~head_empty[bg_eff]),
        .fg_valid     (~head_empty[fg_eff]),
        .out_full     (out_full),
        .bg_key       ({head_y[bg_eff], head_x[bg_eff]}),
        .fg_key       ({head_y[fg_eff], head_x[fg_eff]}),
        .force_unlock (force_unlock),
        .pop_bg       (pop_bg),
        .pop_fg       (pop_fg),
        .emit         (emit),
        .drop         (drop),
        .locked       (locked)
    );

    assign reload       = pop_bg & head_zero[bg_eff];
    assign force_unlock = reload & ((cfg_bg_sel != bg_q) | (cfg_fg_sel != fg_q));

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rd
            logic is_bg;
            logic is_fg;
            assign is_bg        = (bg_eff == CH_W'(gi));
            assign is_fg        = (fg_eff == CH_W'(gi));
            assign in_rd_en[gi] = ~rst & ((is_bg | is_fg) ? ((is_bg & pop_bg) | (is_fg & pop_fg))
                                                          : ~in_empty[gi]);
        end
    endgenerate

    always_comb begin
        colour_d = head_c[bg_eff];
        if (join_en) begin
            if (mode_eff == MODE_KEY) begin
                colour_d = (head_c[fg_eff] == key_eff) ? head_c[bg_eff] : head_c[fg_eff];
            end else begin
                colour_d = (head_x[bg_eff] < split_eff) ? head_c[bg_eff] : head_c[fg_eff];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_PASS;
            bg_q    <= '0;
            fg_q    <= '0;
            key_q   <= '0;
            split_q <= '0;
        end else if (reload) begin
            mode_q  <= decode_mode(cfg_mode);
            bg_q    <= cfg_bg_sel;
            fg_q    <= cfg_fg_sel;
            key_q   <= cfg_key_colour;
            split_q <= cfg_split_x;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_wr_en_q <= 1'b0;
        end else begin
            out_wr_en_q <= emit;
            if (emit) begin
                out_data_q <= {head_x[bg_eff], head_y[bg_eff], colour_d};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (reload) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign out_data         = out_data_q;
    assign out_wr_en        = out_wr_en_q;
    assign sync_locked      = locked;
    assign stat_drop_count  = drop_cnt_q;
    assign stat_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_pixel_stream_router.sv
// Directed bench for pixel_stream_router with three channels: FWFT FIFO models,
// a raster-index join model feeding an expected-output queue, and literal checks.
module tb_pixel_stream_router;

    localparam int NCH = 3;
    localparam int PW  = 38;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      cfg_mode = 2'd0;
    logic [1:0]      cfg_bg_sel = 2'd0;
    logic [1:0]      cfg_fg_sel = 2'd0;
    logic [15:0]     cfg_key_colour = 16'h0;
    logic [10:0]     cfg_split_x = 11'd0;
    logic [NCH*PW-1:0] in_data;
    logic [NCH-1:0]  in_empty;
    logic [NCH-1:0]  in_rd_en;
    logic [PW-1:0]   out_data;
    logic            out_wr_en;
    logic            out_full = 1'b0;
    logic            sync_locked;
    logic [15:0]     stat_drop_count;
    logic [15:0]     stat_frame_count;

    pixel_stream_router #(
        .NUM_CH (NCH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_mode         (cfg_mode),
        .cfg_bg_sel       (cfg_bg_sel),
        .cfg_fg_sel       (cfg_fg_sel),
        .cfg_key_colour   (cfg_key_colour),
        .cfg_split_x      (cfg_split_x),
        .in_data          (in_data),
        .in_empty         (in_empty),
        .in_rd_en         (in_rd_en),
        .out_data         (out_data),
        .out_wr_en        (out_wr_en),
        .out_full         (out_full),
        .sync_locked      (sync_locked),
        .stat_drop_count  (stat_drop_count),
        .stat_frame_count (stat_frame_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_drops = 0;
    logic cmp_en = 1'b1;
    logic mon_en = 1'b0;
    logic saw_unlock = 1'b0;
    logic [NCH-1:0] rd_snap = '0;

    logic [PW-1:0] f0[$], f1[$], f2[$];
    logic [PW-1:0] m_bg[$], m_fg[$], exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int x, input int y, input logic [15:0] c);
        return {x[10:0], y[10:0], c};
    endfunction

    function automatic int raster(input logic [PW-1:0] p);
        return int'(p[26:16]) * 2048 + int'(p[37:27]);
    endfunction

    // Join two coordinate-ordered streams by raster index: equal indices are
    // composited, otherwise the earlier one is discarded (frame start never is).
    task automatic model_run(input int mode, input logic [15:0] key, input int split);
        logic [PW-1:0] b, f;
        logic [15:0]   c;
        while (m_bg.size() > 0 && (mode == 0 || m_fg.size() > 0)) begin
            b = m_bg[0];
            if (mode == 0) begin
                exp_q.push_back(b);
                void'(m_bg.pop_front());
            end else begin
                f = m_fg[0];
                if (raster(b) == raster(f)) begin
                    if (mode == 1) c = (f[15:0] == key) ? b[15:0] : f[15:0];
                    else           c = (int'(b[37:27]) < split) ? b[15:0] : f[15:0];
                    exp_q.push_back({b[37:16], c});
                    void'(m_bg.pop_front());
                    void'(m_fg.pop_front());
                end else begin
                    exp_drops++;
                    if (raster(b) == 0)                 void'(m_fg.pop_front());
                    else if (raster(f) == 0)            void'(m_bg.pop_front());
                    else if (raster(b) < raster(f))     void'(m_bg.pop_front());
                    else                                void'(m_fg.pop_front());
                end
            end
        end
    endtask

    task automatic drive();
        in_empty[0] = (f0.size() == 0);
        in_empty[1] = (f1.size() == 0);
        in_empty[2] = (f2.size() == 0);
        in_data[0*PW +: PW] = (f0.size() != 0) ? f0[0] : '0;
        in_data[1*PW +: PW] = (f1.size() != 0) ? f1[0] : '0;
        in_data[2*PW +: PW] = (f2.size() != 0) ? f2[0] : '0;
    endtask

    initial drive();

    always @(negedge clk) rd_snap = in_rd_en;

    always @(posedge clk) begin
        #1;
        if (rd_snap[0] && f0.size() > 0) void'(f0.pop_front());
        if (rd_snap[1] && f1.size() > 0) void'(f1.pop_front());
        if (rd_snap[2] && f2.size() > 0) void'(f2.pop_front());
        #1;
        drive();
    end

    always @(negedge clk) begin
        if (mon_en && !sync_locked) saw_unlock = 1'b1;
        if (cmp_en && !rst && out_wr_en) begin
            $display("[TB] wr x=%0d y=%0d col=%h", out_data[37:27], out_data[26:16], out_data[15:0]);
            if (exp_q.size() == 0) begin
                chk("out_unexpected_write", {26'd0, out_data}, 64'h0);
            end else begin
                chk("out_data", {26'd0, out_data}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((f0.size() + f1.size() + f2.size() + exp_q.size()) != 0 && n < 300) begin
            tick(1);
            n++;
        end
        tick(2);
        chk({name, "_drained"}, 64'(f0.size() + f1.size() + f2.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_rd_en", 64'(in_rd_en), 64'd0);
        chk("rst_wr_en", 64'(out_wr_en), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_locked", 64'(sync_locked), 64'd0);
        chk("rst_counts", {32'd0, stat_drop_count, stat_frame_count}, 64'd0);
        @(posedge clk); #1;

        // PASS on ch1 with noise on ch0/ch2
        cfg_mode = 2'd0; cfg_bg_sel = 2'd1; cfg_fg_sel = 2'd1;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
                f1.push_back(pix(x, y, 16'h1000 + 16'(y*4 + x)));
                m_bg.push_back(pix(x, y, 16'h1000 + 16'(y*4 + x)));
            end
        for (int i = 0; i < 5; i++) f0.push_back(pix(7, 7, 16'hDEAD));
        for (int i = 0; i < 3; i++) f2.push_back(pix(5, 5, 16'hBEEF));
        model_run(0, 16'h0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("p1_pop_cycle", {60'd0, in_rd_en, out_wr_en}, {60'd0, 3'b111, 1'b0});
        @(negedge clk);
        chk("p1_first_write", {25'd0, out_wr_en, out_data}, {25'd0, 1'b1, pix(0, 0, 16'h1000)});
        @(posedge clk); #1;
        wait_idle("p1");
        chk("p1_frames", 64'(stat_frame_count), 64'd1);
        chk("p1_drops", 64'(stat_drop_count), 64'd0);
        chk("p1_locked", 64'(sync_locked), 64'd1);

        // KEY: fg alternates key/green over blue bg
        cfg_mode = 2'd1; cfg_bg_sel = 2'd0; cfg_fg_sel = 2'd1; cfg_key_colour = 16'hF81F;
        for (int x = 0; x < 4; x++) begin
            f0.push_back(pix(x, 0, 16'h001F));   m_bg.push_back(pix(x, 0, 16'h001F));
            f1.push_back(pix(x, 0, (x % 2 == 0) ? 16'hF81F : 16'h07E0));
            m_fg.push_back(pix(x, 0, (x % 2 == 0) ? 16'hF81F : 16'h07E0));
        end
        model_run(1, 16'hF81F, 0);
        chk("p2_model_pin", {exp_q[0][15:0], exp_q[1][15:0], exp_q[2][15:0], exp_q[3][15:0]},
            64'h001F_07E0_001F_07E0);
        wait_idle("p2");
        chk("p2_frames", 64'(stat_frame_count), 64'd2);
        chk("p2_locked", 64'(sync_locked), 64'd1);

        // SPLIT at x=2
        cfg_mode = 2'd2; cfg_split_x = 11'd2;
        for (int x = 0; x < 4; x++) begin
            f0.push_back(pix(x, 0, 16'hAAAA)); m_bg.push_back(pix(x, 0, 16'hAAAA));
            f1.push_back(pix(x, 0, 16'h5555)); m_fg.push_back(pix(x, 0, 16'h5555));
        end
        model_run(2, 16'h0, 2);
        chk("p3_model_pin", {exp_q[0][15:0], exp_q[1][15:0], exp_q[2][15:0], exp_q[3][15:0]},
            64'hAAAA_AAAA_5555_5555);
        wait_idle("p3");
        chk("p3_frames", 64'(stat_frame_count), 64'd3);

        // fg leads bg by three pixels on line y=1
        saw_unlock = 1'b0; mon_en = 1'b1;
        for (int x = 0; x < 6; x++) begin
            f0.push_back(pix(x, 1, 16'h1111)); m_bg.push_back(pix(x, 1, 16'h1111));
        end
        for (int x = 3; x < 6; x++) begin
            f1.push_back(pix(x, 1, 16'h2222)); m_fg.push_back(pix(x, 1, 16'h2222));
        end
        model_run(2, 16'h0, 2);
        wait_idle("p4");
        mon_en = 1'b0;
        chk("p4_drops_literal", 64'(stat_drop_count), 64'd3);
        chk("p4_drops_model", 64'(stat_drop_count), 64'(exp_drops));
        chk("p4_saw_unlock", 64'(saw_unlock), 64'd1);
        chk("p4_relocked", 64'(sync_locked), 64'd1);

        // out_full held five cycles mid-line
        for (int x = 0; x < 10; x++) begin
            f0.push_back(pix(x, 2, 16'h3000 + 16'(x))); m_bg.push_back(pix(x, 2, 16'h3000 + 16'(x)));
            f1.push_back(pix(x, 2, 16'h4000 + 16'(x))); m_fg.push_back(pix(x, 2, 16'h4000 + 16'(x)));
        end
        model_run(2, 16'h0, 2);
        tick(3);
        out_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("p5_hold_no_pop", 64'(in_rd_en[1:0]), 64'd0);
            if (k > 0) chk("p5_hold_no_write", 64'(out_wr_en), 64'd0);
            @(posedge clk); #1;
        end
        out_full = 1'b0;
        wait_idle("p5");

        // PASS frame with a mid-frame switch request to KEY
        cfg_mode = 2'd0; cfg_bg_sel = 2'd0; cfg_fg_sel = 2'd0;
        for (int x = 0; x < 6; x++) begin
            f0.push_back(pix(x, 0, 16'h6000 + 16'(x))); m_bg.push_back(pix(x, 0, 16'h6000 + 16'(x)));
        end
        model_run(0, 16'h0, 0);
        tick(2);
        cfg_mode = 2'd1; cfg_fg_sel = 2'd1; cfg_key_colour = 16'h0;
        wait_idle("p6");
        chk("p6_frames", 64'(stat_frame_count), 64'd4);

        // Reset mid-line
        cmp_en = 1'b0;
        for (int x = 0; x < 8; x++) f0.push_back(pix(x, 1, 16'h6100));
        tick(3);
        rst = 1'b1;
        @(negedge clk);
        chk("p7_rst_rd_en", 64'(in_rd_en), 64'd0);
        chk("p7_rst_outputs", {25'd0, out_wr_en, out_data}, 64'd0);
        chk("p7_rst_state", {31'd0, sync_locked, stat_drop_count, stat_frame_count}, 64'd0);
        @(posedge clk); #1;
        f0.delete(); f1.delete(); f2.delete(); exp_q.delete();
        tick(2);
        rst = 1'b0;
        cmp_en = 1'b1;
        for (int x = 0; x < 3; x++) begin
            f0.push_back(pix(x, 3, 16'h7000 + 16'(x))); m_bg.push_back(pix(x, 3, 16'h7000 + 16'(x)));
        end
        model_run(0, 16'h0, 0);
        wait_idle("p7");
        chk("p7_locked", 64'(sync_locked), 64'd1);
        chk("p7_frames", 64'(stat_frame_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_stream_router.md
# pixel_stream_router

Parametrised successor to the single-path ADC→DAC pixel forwarding in the top level. The block sits in the 160 MHz core domain between N ADC-side pixel FIFOs and the DAC-side pixel FIFO. It selects and composites up to two frame-aligned input streams in one of three modes: pass-through, chroma-key overlay, or vertical split. Streams are aligned by pixel coordinate, mode and config changes are applied only at frame boundaries, and alignment statistics are exposed.

## Interface
- NUM_CH, 2, number of input pixel channels (2..8)
- X_W, 11, x coordinate width
- Y_W, 11, y coordinate width
- COL_W, 16, RGB565 colour width
- PIX_W, X_W+Y_W+COL_W (38), pixel word layout {x, y, colour}, with x in the MSBs
- CH_W, $clog2(NUM_CH), channel select width

Ports:
- clk  in  1  core pixel clock (clk160 at top level)
- rst  in  1  asynchronous, active-high reset
- cfg_mode  in  2  0=PASS, 1=KEY, 2=SPLIT, 3=reserved (treated as PASS)
- cfg_bg_sel  in  CH_W  background channel
- cfg_fg_sel  in  CH_W  foreground channel
- cfg_key_colour  in  COL_W  transparent colour for KEY mode
- cfg_split_x  in  X_W  first x column taken from fg in SPLIT mode
- in_data  in  NUM_CH*PIX_W  FWFT FIFO heads; channel i occupies [i*PIX_W +: PIX_W]
- in_empty  in  NUM_CH  FIFO empty flags
- in_rd_en  out  NUM_CH  pop strobes
- out_data  out  PIX_W  pixel to the DAC FIFO
- out_wr_en  out  1  write strobe to the DAC FIFO
- out_full  in  1  DAC FIFO prog-full; asserts with at least 2 free entries
- sync_locked  out  1  bg and fg streams are coordinate-aligned
- stat_drop_count  out  16  pixels discarded to realign; saturates at 0xFFFF
- stat_frame_count  out  16  frames emitted; wraps

## Operation
- Active config (mode, bg, fg, key, split) is a register set.
  - Reset values: PASS, 0, 0, 0, 0.
  - The register set reloads from cfg_* in the same cycle that a bg head with x=0, y=0 is popped. That pixel uses the new config.
  - stat_frame_count increments on that same pop.
- Unused channels: any channel that is neither active bg nor active fg has in_rd_en = ~in_empty every cycle, so it drains continuously.
- PASS mode, or KEY/SPLIT with fg==bg:
  - Pop bg when ~in_empty[bg] & ~out_full.
  - Emit the bg pixel unchanged.
  - sync_locked=1.
- KEY/SPLIT with fg≠bg: two-channel join. Heads are valid only when both FIFOs are non-empty and ~out_full. Compare the coordinates as the key {y, x}:
  - Equal: pop both and emit. Coordinates are taken from bg.
    - KEY colour = (fg.colour==key) ? bg.colour : fg.colour.
    - SPLIT colour = (x < split_x) ? bg.colour : fg.colour.
  - Unequal: pop only the smaller-key head (the lagging stream). No emit. stat_drop_count++.
  - A head at (0,0) is never treated as lagging; the other head is dropped instead.
- Lock FSM, two states:
  - UNLOCKED→LOCKED on an equal-coordinate pop.
  - LOCKED→UNLOCKED on any drop.
  - A config reload that changes bg or fg forces UNLOCKED.
  - sync_locked = (state==LOCKED) in join modes.
- Colour arithmetic is pure selection, with no blending.

## Timing
- Pop decision is combinational from in_empty and out_full. in_rd_en is asserted in the pop cycle.
- out_data and out_wr_en are registered: out_wr_en is high exactly one cycle after the pop cycle.
- Throughput is 1 pixel/cycle when heads are available and ~out_full.
- out_full is sampled in the pop cycle. The 2-entry headroom covers the registered write.
- Reset state:
  - in_rd_en=0, out_wr_en=0, out_data=0.
  - sync_locked=0; it rises after the first PASS pop or the first matched join.
  - Counters are 0.
  - FSM is UNLOCKED.
- Reset mid-frame: the pipeline register is cleared and the in-flight pixel is lost. After release, config stays at reset values until the next (0,0).
- Simultaneous reload and drop in the same cycle: the drop is counted, the reload is applied, and the state is UNLOCKED.
- cfg_* may change at any time. Only the value present at a (0,0) pop matters.

## Structure
- Package pixel_pkg holds:
  - pixel_t struct {x, y, colour}
  - mode_e enum (PASS, KEY, SPLIT)
  - X_W, Y_W and COL_W defaults
  - a coord_lt function
- Sub-module pixel_join contains the two-channel coordinate aligner: the compare, the pop/drop decision, and the lock FSM.
- The top of the block holds:
  - channel muxing
  - config shadow registers
  - compositing
  - the output register
  - counters

## Test plan
- PASS, bg=1, NUM_CH=3; ch1 carries a 4×2 frame from (0,0) and ch0/ch2 carry noise → out carries exactly the ch1 words in order, one cycle after each pop; ch0/ch2 are drained; stat_frame_count=1.
- KEY, key=0xF81F; fg pixels alternate 0xF81F and 0x07E0 over bg 0x001F → output alternates 0x001F and 0x07E0; sync_locked=1.
- SPLIT, split_x=2, 4-wide line → x=0,1 take bg colour and x=2,3 take fg colour.
- fg leads by 3 pixels → 3 bg heads are dropped, stat_drop_count=3, sync_locked goes 0 then 1, then matched output follows.
- out_full held for 5 cycles mid-line → no pops and no writes during the hold; no pixel lost or duplicated after release.
- cfg_mode changed from PASS to KEY mid-frame → no effect until the next (0,0); rst asserted mid-line → all outputs go to 0 immediately and config returns to PASS/ch0.
